// File: rtl/pm_fetch_unit.sv
// Instruction fetch: PC, next-address mux and synchronous program ROM.
// Registered fetch with absolute/relative jumps, stalls, bubbles, fault flag.
module pm_fetch_unit #(
  parameter int              ADDR_W     = 16,
  parameter int              INS_W      = 32,
  parameter int              DEPTH      = 256,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [INS_W-1:0]  NOP        = '0,
  parameter string           INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              pc_mux_sel,
  input  logic              rel_mode,
  input  logic              stall,
  input  logic              stall_pm,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] current_address,
  output logic              ins_valid,
  output logic              addr_fault
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [INS_W-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP;
  end

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] fa;
  logic              in_rng;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    tgt     = rel_mode ? (cur_q + jmp_loc) : jmp_loc;
    fa      = pc_mux_sel ? tgt : pc_q;
    in_rng  = {1'b0, fa} < DEPTH_LIM;
    idx     = fa[IDX_W-1:0];
    pc_d    = pc_q;
    cur_d   = cur_q;
    ins_d   = ins_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (stall_pm) begin
      ins_d   = NOP;
      valid_d = 1'b0;
    end else begin
      pc_d  = fa + ADDR_W'(1);
      cur_d = fa;
      if (in_rng) begin
        ins_d   = mem[idx];
        valid_d = 1'b1;
      end else begin
        ins_d   = NOP;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      cur_q   <= RESET_ADDR;
      ins_q   <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cur_q   <= cur_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign ins             = ins_q;
  assign current_address = cur_q;
  assign ins_valid       = valid_q;
  assign addr_fault      = fault_q;

endmodule

// File: tb/tb_pm_fetch_unit.sv
// Directed bench for pm_fetch_unit with an in-bench reference model
// and hand-computed literal checks; image is mem[i] = A000_0000 + i.
module tb_pm_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] jmp_loc = '0;
  logic        pc_mux_sel = 1'b0;
  logic        rel_mode = 1'b0;
  logic        stall = 1'b0;
  logic        stall_pm = 1'b0;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        ins_valid;
  logic        addr_fault;

  int checks = 0;
  int errors = 0;

  pm_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .jmp_loc(jmp_loc),
    .pc_mux_sel(pc_mux_sel),
    .rel_mode(rel_mode),
    .stall(stall),
    .stall_pm(stall_pm),
    .ins(ins),
    .current_address(current_address),
    .ins_valid(ins_valid),
    .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, rules applied per rising edge.
  int unsigned m_pc, m_cur, m_ins;
  bit          m_valid, m_fault;
  bit          m_ok = 1'b0;

  function automatic int unsigned image(int unsigned a);
    return 32'hA000_0000 + a;
  endfunction

  always @(posedge clk) begin
    int unsigned fa;
    if (reset) begin
      m_pc = 0; m_cur = 0; m_ins = 0;
      m_valid = 0; m_fault = 0; m_ok = 1;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (stall_pm) begin
      m_ins = 0; m_valid = 0;
    end else begin
      if (!pc_mux_sel) fa = m_pc;
      else if (rel_mode) fa = (m_cur + jmp_loc) % 65536;
      else fa = jmp_loc;
      m_cur = fa;
      m_pc  = (fa + 1) % 65536;
      if (fa < 256) begin
        m_ins = image(fa); m_valid = 1;
      end else begin
        m_ins = 0; m_valid = 0; m_fault = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checks += 4;
      if (ins !== m_ins) begin
        errors++;
        $display("FAIL model_ins got %h want %h", ins, m_ins);
      end
      if (current_address !== 16'(m_cur)) begin
        errors++;
        $display("FAIL model_addr got %h want %h", current_address, m_cur);
      end
      if (ins_valid !== m_valid) begin
        errors++;
        $display("FAIL model_valid got %b want %b", ins_valid, m_valid);
      end
      if (addr_fault !== m_fault) begin
        errors++;
        $display("FAIL model_fault got %b want %b", addr_fault, m_fault);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic out4(input string nm, input logic [31:0] i,
                      input logic [15:0] a, input logic v,
                      input logic f);
    chk({nm, "_ins"}, ins, i);
    chk({nm, "_addr"}, 32'(current_address), 32'(a));
    chk({nm, "_valid"}, 32'(ins_valid), 32'(v));
    chk({nm, "_fault"}, 32'(addr_fault), 32'(f));
  endtask

  task automatic jump(input logic [15:0] t, input logic rel);
    pc_mux_sel = 1'b1; rel_mode = rel; jmp_loc = t;
    tick();
    pc_mux_sel = 1'b0; rel_mode = 1'b0; jmp_loc = '0;
  endtask

  initial begin
    #1;
    for (int i = 0; i < 256; i++) dut.mem[i] = 32'hA000_0000 + i;

    tick();
    tick();
    out4("reset", 32'h0, 16'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    out4("seq0", 32'hA000_0000, 16'h0, 1'b1, 1'b0);
    tick();
    chk("seq1", ins, 32'hA000_0001);
    tick();
    chk("seq2", ins, 32'hA000_0002);
    tick();
    chk("seq3_addr", 32'(current_address), 32'h3);

    jump(16'h0008, 1'b0);
    out4("abs_jmp", 32'hA000_0008, 16'h8, 1'b1, 1'b0);
    tick();
    chk("abs_next", ins, 32'hA000_0009);

    repeat (7) tick();
    chk("at_10", 32'(current_address), 32'h10);
    jump(16'hFFFC, 1'b1);
    out4("rel_neg", 32'hA000_000C, 16'hC, 1'b1, 1'b0);
    jump(16'h0010, 1'b0);
    jump(16'h0005, 1'b1);
    chk("rel_pos", ins, 32'hA000_0015);
    tick();
    chk("rel_next", ins, 32'hA000_0016);

    jump(16'h0005, 1'b0);
    stall = 1'b1;
    tick();
    out4("stall1", 32'hA000_0005, 16'h5, 1'b1, 1'b0);
    tick();
    out4("stall2", 32'hA000_0005, 16'h5, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    chk("stall_rel", ins, 32'hA000_0006);
    stall_pm = 1'b1;
    tick();
    out4("bubble", 32'h0, 16'h6, 1'b0, 1'b0);
    stall_pm = 1'b0;
    tick();
    out4("bub_rel", 32'hA000_0007, 16'h7, 1'b1, 1'b0);
    stall = 1'b1; stall_pm = 1'b1;
    tick();
    out4("both", 32'hA000_0007, 16'h7, 1'b1, 1'b0);
    stall = 1'b0; stall_pm = 1'b0;
    tick();
    chk("both_rel", ins, 32'hA000_0008);

    stall = 1'b1; pc_mux_sel = 1'b1; jmp_loc = 16'h0040;
    tick();
    chk("jmp_stall", 32'(current_address), 32'h8);
    stall = 1'b0; pc_mux_sel = 1'b0; jmp_loc = '0;
    tick();
    chk("jmp_lost", ins, 32'hA000_0009);
    jump(16'h0040, 1'b0);
    chk("jmp_retry", ins, 32'hA000_0040);

    jump(16'h0100, 1'b0);
    out4("fault", 32'h0, 16'h100, 1'b0, 1'b1);
    tick();
    out4("fault_seq", 32'h0, 16'h101, 1'b0, 1'b1);
    jump(16'h0002, 1'b0);
    out4("fault_sticky", 32'hA000_0002, 16'h2, 1'b1, 1'b1);

    jump(16'hFFFF, 1'b0);
    chk("wrap_top", 32'(current_address), 32'hFFFF);
    tick();
    out4("wrap", 32'hA000_0000, 16'h0, 1'b1, 1'b1);
    tick();

    stall = 1'b1; reset = 1'b1; pc_mux_sel = 1'b1; jmp_loc = 16'h0030;
    tick();
    out4("rst_mid", 32'h0, 16'h0, 1'b0, 1'b0);
    stall = 1'b0; reset = 1'b0; pc_mux_sel = 1'b0; jmp_loc = '0;
    tick();
    out4("rst_rel", 32'hA000_0000, 16'h0, 1'b1, 1'b0);
    tick();
    chk("rst_seq", ins, 32'hA000_0001);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
